dmem_bus_demux: RTL

Single-outstanding 1:2 request router between the core's load/store unit and two data-side targets: port 0 (data RAM) and port 1 (MMIO). Decodes the request address, forwards the request to the selected port with a valid/ready handshake, and routes that port's response back to the core. It performs the split; the write-back path recombines results downstream.

---
 rtl/dmem_bus_pkg.sv | 23 ++
 rtl/dmem_addr_decode.sv | 25 ++
 rtl/dmem_bus_demux.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_bus_pkg.sv
// Shared types and default address map for the data-side request router.
// Feature macro: DMEM_DECERR_EN (decode-error response for unmapped addresses).
package dmem_bus_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      ERR   = 3'd4
   } state_e;

   typedef enum logic {
      SEL_RAM  = 1'b0,
      SEL_MMIO = 1'b1
   } sel_e;

   localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] DEF_RAM_SIZE  = 32'h0001_0000;
   localparam logic [31:0] DEF_MMIO_BASE = 32'h1000_0000;
   localparam logic [31:0] DEF_MMIO_SIZE = 32'h0000_1000;

endpackage

// File: rtl/dmem_addr_decode.sv
// Combinational window decode for the RAM and MMIO targets.
// Offsets are taken modulo 2^32 so an address below a base can never hit it.
module dmem_addr_decode #(
   parameter logic [31:0] RAM_BASE  = dmem_bus_pkg::DEF_RAM_BASE,
   parameter logic [31:0] RAM_SIZE  = dmem_bus_pkg::DEF_RAM_SIZE,
   parameter logic [31:0] MMIO_BASE = dmem_bus_pkg::DEF_MMIO_BASE,
   parameter logic [31:0] MMIO_SIZE = dmem_bus_pkg::DEF_MMIO_SIZE
) (
   input  logic [31:0] addr,
   output logic        hit0,
   output logic        hit1,
   output logic        unmapped
);

   logic [31:0] ram_off;
   logic [31:0] mmio_off;

   assign ram_off  = addr - RAM_BASE;
   assign mmio_off = addr - MMIO_BASE;

   assign hit0     = ram_off < RAM_SIZE;
   assign hit1     = mmio_off < MMIO_SIZE;
   assign unmapped = !hit0 && !hit1;

endmodule

// File: rtl/dmem_bus_demux.sv
// Single-outstanding 1:2 router from the load/store unit to data RAM (port 0) and MMIO (port 1).
// Feature macro: DMEM_DECERR_EN -- unmapped addresses get an error response instead of going to port 1.
module dmem_bus_demux
   import dmem_bus_pkg::*;
#(
   parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
   parameter logic [31:0] RAM_SIZE  = DEF_RAM_SIZE,
   parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
   parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        m0_valid,
   input  logic        m0_ready,
   output logic [31:0] m0_addr,
   output logic [31:0] m0_wdata,
   output logic        m0_we,
   output logic [3:0]  m0_be,
   input  logic        m0_rsp_valid,
   input  logic [31:0] m0_rsp_rdata,
   output logic        m1_valid,
   input  logic        m1_ready,
   output logic [31:0] m1_addr,
   output logic [31:0] m1_wdata,
   output logic        m1_we,
   output logic [3:0]  m1_be,
   input  logic        m1_rsp_valid,
   input  logic [31:0] m1_rsp_rdata
);

   state_e      state_q, state_d;
   sel_e        sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;

   logic        hit0, hit1, unmapped;
   logic        unused_dec;
   logic        sel_ready;
   logic        sel_rsp_valid;
   logic [31:0] sel_rsp_rdata;

   dmem_addr_decode #(
      .RAM_BASE (RAM_BASE),
      .RAM_SIZE (RAM_SIZE),
      .MMIO_BASE(MMIO_BASE),
      .MMIO_SIZE(MMIO_SIZE)
   ) u_decode (
      .addr    (req_addr),
      .hit0    (hit0),
      .hit1    (hit1),
      .unmapped(unmapped)
   );

   // Port 1 is chosen as "not port 0", so hit1 only matters through unmapped.
`ifdef DMEM_DECERR_EN
   assign unused_dec = hit1;
`else
   assign unused_dec = hit1 ^ unmapped;
`endif

   assign sel_ready     = (sel_q == SEL_MMIO) ? m1_ready     : m0_ready;
   assign sel_rsp_valid = (sel_q == SEL_MMIO) ? m1_rsp_valid : m0_rsp_valid;
   assign sel_rsp_rdata = (sel_q == SEL_MMIO) ? m1_rsp_rdata : m0_rsp_rdata;

   always_comb begin
      // NOTE: every _d is defaulted to its _q first so no path through the case can infer a latch.
      state_d = state_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               we_d    = req_we;
               be_d    = req_be;
               rdata_d = '0;
               sel_d   = hit0 ? SEL_RAM : SEL_MMIO;
`ifdef DMEM_DECERR_EN
               state_d = unmapped ? ERR : ISSUE;
`else
               state_d = ISSUE;
`endif
            end
         end
         ISSUE: if (sel_ready) state_d = WAIT;
         WAIT: begin
            if (sel_rsp_valid) begin
               rdata_d = we_q ? '0 : sel_rsp_rdata;
               state_d = RESP;
            end
         end
         RESP, ERR: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= SEL_RAM;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of order.
         state_q <= state_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   // State sits at IDLE during reset, so req_ready is explicitly gated by rst_n.
   assign req_ready = rst_n && (state_q == IDLE);
   assign rsp_valid = (state_q == RESP) || (state_q == ERR);
   assign rsp_rdata = rdata_q;
`ifdef DMEM_DECERR_EN
   assign rsp_err   = (state_q == ERR);
`else
   assign rsp_err   = 1'b0;
`endif

   assign m0_valid = (state_q == ISSUE) && (sel_q == SEL_RAM);
   assign m1_valid = (state_q == ISSUE) && (sel_q == SEL_MMIO);
   assign m0_addr  = addr_q;
   assign m0_wdata = wdata_q;
   assign m0_we    = we_q;
   assign m0_be    = be_q;
   assign m1_addr  = addr_q;
   assign m1_wdata = wdata_q;
   assign m1_we    = we_q;
   assign m1_be    = be_q;

endmodule
